// File: rtl/riscv_v_hazard_ctrl.sv
// Vector pipeline hazard/issue controller: RAW detection on vector and mask
// register files, ID-stage bypass selection and multiplier occupancy tracking.
module riscv_v_hazard_ctrl #(
    parameter int RF_ADDR_W   = 5,
    parameter int MUL_LATENCY = 3,
    parameter int FWD_EN      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 riscv_stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [RF_ADDR_W-1:0] vs1_id,
    input  logic [RF_ADDR_W-1:0] vs2_id,
    input  logic                 vs1_rd_id,
    input  logic                 vs2_rd_id,
    input  logic [RF_ADDR_W-1:0] vd_id,
    input  logic                 vd_wr_id,
    input  logic                 mask_rd_id,
    input  logic                 mask_wr_id,
    input  logic                 is_mul_id,
    output logic                 riscv_v_stall,
    output logic [1:0]           fwd_srca_sel_id,
    output logic [1:0]           fwd_srcb_sel_id,
    output logic                 issue_exe,
    output logic                 mul_busy
);

    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CW-1:0] MCNT_LOAD = CW'(MUL_LATENCY - 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXE = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic                 exe_valid_q, exe_valid_d;
    logic [RF_ADDR_W-1:0] exe_vd_q, exe_vd_d;
    logic                 exe_vd_wr_q, exe_vd_wr_d;
    logic                 exe_mask_wr_q, exe_mask_wr_d;
    logic                 exe_mul_q, exe_mul_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [RF_ADDR_W-1:0] wb_vd_q, wb_vd_d;
    logic                 wb_vd_wr_q, wb_vd_wr_d;
    logic                 wb_mask_wr_q, wb_mask_wr_d;
    logic [CW-1:0]        mcnt_q, mcnt_d;

    logic                 haz_a, haz_b;
    logic [1:0]           raw_sel_a, raw_sel_b;
    logic                 mask_haz, struct_haz;

    assign mul_busy  = exe_mul_q & (mcnt_q != '0);
    assign issue_exe = exe_valid_q;

    // One source operand: {hazard, bypass select}; EXE match beats WB match.
    function automatic logic [2:0] src_check(
        input logic                 rd,
        input logic [RF_ADDR_W-1:0] vs
    );
        logic [2:0] r;
        logic       exe_hit;
        logic       wb_hit;
        r       = {1'b0, SEL_RF};
        exe_hit = exe_valid_q & exe_vd_wr_q & (exe_vd_q == vs);
        wb_hit  = wb_valid_q & wb_vd_wr_q & (wb_vd_q == vs);
        if (rd) begin
            if (exe_hit) begin
                if (mul_busy || (FWD_EN == 0)) r = {1'b1, SEL_RF};
                else                           r = {1'b0, SEL_EXE};
            end else if (wb_hit) begin
                if (FWD_EN != 0) r = {1'b0, SEL_WB};
                else             r = {1'b1, SEL_RF};
            end
        end
        return r;
    endfunction

    // Hazard detection and operand select generation for the ID instruction.
    always_comb begin
        {haz_a, raw_sel_a} = src_check(id_valid & vs1_rd_id, vs1_id);
        {haz_b, raw_sel_b} = src_check(id_valid & vs2_rd_id, vs2_id);
        mask_haz   = id_valid & mask_rd_id &
                     ((exe_valid_q & exe_mask_wr_q) |
                      (wb_valid_q & wb_mask_wr_q));
        struct_haz = id_valid & mul_busy;
        riscv_v_stall   = haz_a | haz_b | mask_haz | struct_haz;
        fwd_srca_sel_id = riscv_v_stall ? SEL_RF : raw_sel_a;
        fwd_srcb_sel_id = riscv_v_stall ? SEL_RF : raw_sel_b;
    end

    // Next state of the EXE/WB tracking slots and multiplier counter.
    always_comb begin
        exe_valid_d   = exe_valid_q;
        exe_vd_d      = exe_vd_q;
        exe_vd_wr_d   = exe_vd_wr_q;
        exe_mask_wr_d = exe_mask_wr_q;
        exe_mul_d     = exe_mul_q;
        wb_valid_d    = wb_valid_q;
        wb_vd_d       = wb_vd_q;
        wb_vd_wr_d    = wb_vd_wr_q;
        wb_mask_wr_d  = wb_mask_wr_q;
        mcnt_d        = mcnt_q;
        if (flush) begin
            exe_valid_d = 1'b0;
            exe_mul_d   = 1'b0;
            wb_valid_d  = 1'b0;
            mcnt_d      = '0;
        end else if (riscv_stall) begin
            mcnt_d = mcnt_q;
        end else if (mul_busy) begin
            mcnt_d     = mcnt_q - CW'(1);
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d   = exe_valid_q;
            wb_vd_d      = exe_vd_q;
            wb_vd_wr_d   = exe_vd_wr_q;
            wb_mask_wr_d = exe_mask_wr_q;
            if (riscv_v_stall) begin
                exe_valid_d = 1'b0;
                exe_mul_d   = 1'b0;
                mcnt_d      = '0;
            end else begin
                exe_valid_d   = id_valid;
                exe_vd_d      = vd_id;
                exe_vd_wr_d   = vd_wr_id;
                exe_mask_wr_d = mask_wr_id;
                exe_mul_d     = id_valid & is_mul_id;
                mcnt_d        = (id_valid & is_mul_id) ? MCNT_LOAD : '0;
            end
        end
    end

    // Slot and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_valid_q   <= 1'b0;
            exe_vd_q      <= '0;
            exe_vd_wr_q   <= 1'b0;
            exe_mask_wr_q <= 1'b0;
            exe_mul_q     <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_vd_q       <= '0;
            wb_vd_wr_q    <= 1'b0;
            wb_mask_wr_q  <= 1'b0;
            mcnt_q        <= '0;
        end else begin
            exe_valid_q   <= exe_valid_d;
            exe_vd_q      <= exe_vd_d;
            exe_vd_wr_q   <= exe_vd_wr_d;
            exe_mask_wr_q <= exe_mask_wr_d;
            exe_mul_q     <= exe_mul_d;
            wb_valid_q    <= wb_valid_d;
            wb_vd_q       <= wb_vd_d;
            wb_vd_wr_q    <= wb_vd_wr_d;
            wb_mask_wr_q  <= wb_mask_wr_d;
            mcnt_q        <= mcnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_v_hazard_ctrl.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_riscv_v_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       riscv_stall;
    logic       flush;
    logic       id_valid;
    logic [4:0] vs1_id, vs2_id, vd_id;
    logic       vs1_rd_id, vs2_rd_id, vd_wr_id;
    logic       mask_rd_id, mask_wr_id, is_mul_id;

    logic       st_a, iss_a, mb_a;
    logic [1:0] sa_a, sb_a;
    logic       st_b, iss_b, mb_b;
    logic [1:0] sa_b, sb_b;

    always #5 clk = ~clk;

    riscv_v_hazard_ctrl #(.RF_ADDR_W(5), .MUL_LATENCY(3), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .riscv_stall(riscv_stall), .flush(flush),
        .id_valid(id_valid), .vs1_id(vs1_id), .vs2_id(vs2_id),
        .vs1_rd_id(vs1_rd_id), .vs2_rd_id(vs2_rd_id), .vd_id(vd_id),
        .vd_wr_id(vd_wr_id), .mask_rd_id(mask_rd_id), .mask_wr_id(mask_wr_id),
        .is_mul_id(is_mul_id), .riscv_v_stall(st_a),
        .fwd_srca_sel_id(sa_a), .fwd_srcb_sel_id(sb_a),
        .issue_exe(iss_a), .mul_busy(mb_a)
    );

    riscv_v_hazard_ctrl #(.RF_ADDR_W(5), .MUL_LATENCY(3), .FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst), .riscv_stall(riscv_stall), .flush(flush),
        .id_valid(id_valid), .vs1_id(vs1_id), .vs2_id(vs2_id),
        .vs1_rd_id(vs1_rd_id), .vs2_rd_id(vs2_rd_id), .vd_id(vd_id),
        .vd_wr_id(vd_wr_id), .mask_rd_id(mask_rd_id), .mask_wr_id(mask_wr_id),
        .is_mul_id(is_mul_id), .riscv_v_stall(st_b),
        .fwd_srca_sel_id(sa_b), .fwd_srcb_sel_id(sb_b),
        .issue_exe(iss_b), .mul_busy(mb_b)
    );

    typedef struct {
        string      name;
        logic       st;
        logic [1:0] a;
        logic [1:0] b;
        logic       is;
        logic       mb;
        logic       cb;
        logic       stb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic cmp(input string n, input string f,
                       input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s.%s got=%0h exp=%0h", n, f, got, exp);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "stall", {1'b0, st_a}, {1'b0, e.st});
            cmp(e.name, "sela", sa_a, e.a);
            cmp(e.name, "selb", sb_a, e.b);
            cmp(e.name, "issue", {1'b0, iss_a}, {1'b0, e.is});
            cmp(e.name, "busy", {1'b0, mb_a}, {1'b0, e.mb});
            if (e.cb) cmp(e.name, "stall_nofwd", {1'b0, st_b}, {1'b0, e.stb});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        vs1_id     = '0;
        vs2_id     = '0;
        vd_id      = '0;
        vs1_rd_id  = 1'b0;
        vs2_rd_id  = 1'b0;
        vd_wr_id   = 1'b0;
        mask_rd_id = 1'b0;
        mask_wr_id = 1'b0;
        is_mul_id  = 1'b0;
    endtask

    task automatic ins(input int s1, input bit r1, input int s2, input bit r2,
                       input int d, input bit w, input bit mr = 0,
                       input bit mw = 0, input bit ml = 0);
        id_valid   = 1'b1;
        vs1_id     = s1[4:0];
        vs2_id     = s2[4:0];
        vd_id      = d[4:0];
        vs1_rd_id  = r1;
        vs2_rd_id  = r2;
        vd_wr_id   = w;
        mask_rd_id = mr;
        mask_wr_id = mw;
        is_mul_id  = ml;
    endtask

    task automatic cyc(input string n, input bit st, input bit [1:0] a,
                       input bit [1:0] b, input bit is, input bit mb,
                       input bit cb = 0, input bit stb = 0);
        exp_t e;
        e.name = n;
        e.st   = st;
        e.a    = a;
        e.b    = b;
        e.is   = is;
        e.mb   = mb;
        e.cb   = cb;
        e.stb  = stb;
        q.push_back(e);
        tick();
    endtask

    task automatic rst_cyc();
        rst         = 1'b0;
        flush       = 1'b0;
        riscv_stall = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        flush       = 1'b0;
        riscv_stall = 1'b0;
        idle();
        tick();

        ins(3, 1, 3, 1, 3, 1, 1, 1, 1);
        cyc("rst_c1", 0, 0, 0, 0, 0, 1, 0);
        cyc("rst_c2", 0, 0, 0, 0, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 3, 1);
        cyc("byp_c1", 0, 0, 0, 0, 0);
        ins(3, 1, 0, 0, 10, 1);
        cyc("byp_c2", 0, 2'b01, 0, 1, 0);
        ins(0, 0, 3, 1, 11, 1);
        cyc("byp_c3", 0, 0, 2'b10, 1, 0);
        idle();
        cyc("byp_c4", 0, 0, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 0, 1);
        cyc("v0_c1", 0, 0, 0, 0, 0);
        ins(0, 1, 0, 1, 4, 1);
        cyc("v0_c2", 0, 2'b01, 2'b01, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 5, 1, 0, 0, 1);
        cyc("mul_c1", 0, 0, 0, 0, 0);
        ins(0, 0, 5, 1, 6, 1);
        cyc("mul_c2", 1, 0, 0, 1, 1);
        cyc("mul_c3", 1, 0, 0, 1, 1);
        cyc("mul_c4", 0, 0, 2'b01, 1, 0);
        idle();
        cyc("mul_c5", 0, 0, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 5, 1, 0, 0, 1);
        cyc("str_c1", 0, 0, 0, 0, 0);
        ins(1, 1, 2, 1, 9, 1);
        cyc("str_c2", 1, 0, 0, 1, 1);
        cyc("str_c3", 1, 0, 0, 1, 1);
        cyc("str_c4", 0, 0, 0, 1, 0);
        idle();
        cyc("str_c5", 0, 0, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 8, 1, 0, 1, 0);
        cyc("msk_c1", 0, 0, 0, 0, 0);
        ins(9, 1, 0, 0, 12, 1, 1, 0, 0);
        cyc("msk_c2", 1, 0, 0, 1, 0);
        cyc("msk_c3", 1, 0, 0, 0, 0);
        cyc("msk_c4", 0, 0, 0, 0, 0);
        idle();
        cyc("msk_c5", 0, 0, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 7, 1);
        cyc("nof_c1", 0, 0, 0, 0, 0, 1, 0);
        ins(7, 1, 0, 0, 13, 1);
        cyc("nof_c2", 0, 2'b01, 0, 1, 0, 1, 1);
        cyc("nof_c3", 0, 2'b10, 0, 1, 0, 1, 1);
        cyc("nof_c4", 0, 0, 0, 1, 0, 1, 0);
        idle();
        cyc("nof_c5", 0, 0, 0, 1, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 5, 1, 0, 0, 1);
        cyc("fl_c1", 0, 0, 0, 0, 0);
        ins(5, 1, 0, 0, 6, 1);
        cyc("fl_c2", 1, 0, 0, 1, 1);
        flush       = 1'b1;
        riscv_stall = 1'b1;
        cyc("fl_c3", 1, 0, 0, 1, 1);
        flush       = 1'b0;
        riscv_stall = 1'b0;
        cyc("fl_c4", 0, 0, 0, 0, 0);
        idle();
        cyc("fl_c5", 0, 0, 0, 1, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 5, 1, 0, 0, 1);
        cyc("frz_c1", 0, 0, 0, 0, 0);
        idle();
        cyc("frz_c2", 0, 0, 0, 1, 1);
        riscv_stall = 1'b1;
        for (int i = 0; i < 4; i++) cyc("frz_hold", 0, 0, 0, 1, 1);
        riscv_stall = 1'b0;
        cyc("frz_c7", 0, 0, 0, 1, 1);
        cyc("frz_c8", 0, 0, 0, 1, 0);
        cyc("frz_c9", 0, 0, 0, 0, 0);

        rst_cyc();
        ins(0, 0, 0, 0, 5, 1, 0, 0, 1);
        cyc("rmul_c1", 0, 0, 0, 0, 0);
        idle();
        cyc("rmul_c2", 0, 0, 0, 1, 1);
        rst_cyc();
        ins(5, 1, 0, 0, 6, 1);
        cyc("rmul_c3", 0, 0, 0, 0, 0);
        idle();

        tick();
        tick();
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
